// File: rtl/tcdm_stream_reader_pkg.sv
// Shared types and helpers for the TCDM stream reader.
// Optional perf counter is enabled with TCDM_READER_PERF_CNT_EN.
package tcdm_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BE_MAX = 128;

  // Byte-enable vector with the lowest n bits set; callers cast to their width.
  function automatic logic [BE_MAX-1:0] be_all_ones(input int n);
    logic [BE_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BE_MAX; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Occupancy counters must represent the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tcdm_stream_fifo.sv
// Response buffer for the TCDM stream reader: power-of-2 depth, flush has priority.
// Push while full is only accepted together with a pop.
module tcdm_stream_fifo
  import tcdm_stream_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              push_data_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              pop_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign wr_en = push_i & (~full_o | pop_i) & ~flush_i;
  assign rd_en = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_stream_reader.sv
// Strided TCDM word reader that returns read data as a valid/ready stream.
// Define TCDM_READER_PERF_CNT_EN to add the perf_stall_o grant-stall counter.
module tcdm_stream_reader
  import tcdm_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    tcdm_req_o,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  input  logic                    tcdm_gnt_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o
`ifdef TCDM_READER_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_o
`endif
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int CW   = cnt_width(FIFO_DEPTH);

  // Handshakes: a TCDM request is accepted on req & gnt, and req/addr stay
  // stable until then; a stream beat moves on out_valid & out_ready, and
  // out_valid never depends on out_ready.

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [LEN_WIDTH-1:0]   remain_q;
  logic                   inflight_q;
  logic                   busy_q;
  logic                   done_q;

  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_head;
  logic [CW:0]            credit_used;
  logic                   req;
  logic                   grant;
  logic                   pop;

  // Credits count both buffered words and the one response still on the bus.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign req         = (state_q == ISSUE) && !fifo_full &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign grant       = req & tcdm_gnt_i;
  assign pop         = ~fifo_empty & out_ready_i;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tcdm_req_o  = req;
  assign tcdm_add_o  = addr_q;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = BE_W'(be_all_ones(BE_W));
  assign tcdm_data_o = '0;
  assign out_valid_o = ~fifo_empty;
  assign out_data_o  = fifo_empty ? '0 : fifo_head;

  tcdm_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (clear_i),
    .push_i      (inflight_q),
    .push_data_i (tcdm_r_data_i),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= grant & ~clear_i;
      if (clear_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (len_i != '0) begin
                addr_q   <= base_addr_i;
                stride_q <= stride_i;
                remain_q <= len_i;
                busy_q   <= 1'b1;
                state_q  <= ISSUE;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (grant) begin
              addr_q   <= addr_q + stride_q;
              remain_q <= remain_q - LEN_WIDTH'(1);
              if (remain_q == LEN_WIDTH'(1)) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (!inflight_q && fifo_empty) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef TCDM_READER_PERF_CNT_EN
  logic [31:0] perf_q;
  assign perf_stall_o = perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (state_q == IDLE && start_i && !clear_i) begin
      perf_q <= '0;
    end else if (req && !tcdm_gnt_i && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end
`endif

endmodule
